// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep sequencer.
//   state_e    : sweep controller state encoding
//   Def*W      : default datapath widths
//   addr_lsb() : lowest phase bit that feeds the ROM address
package dds_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam int unsigned DefPhaseW = 16;
  localparam int unsigned DefAddrW  = 5;
  localparam int unsigned DefDataW  = 8;

  // The ROM address is the top addr_w bits of the phase word.
  function automatic int unsigned addr_lsb(input int unsigned phase_w, input int unsigned addr_w);
    return phase_w - addr_w;
  endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator for the DDS sweep.
//   clk       : system clock
//   CR        : synchronous active-high reset, clears phase
//   load      : synchronous clear of phase at sweep start
//   en        : add freq_word to phase this cycle
//   freq_word : phase increment
//   addr      : ROM address slice of the current phase
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = DefPhaseW,
  parameter int unsigned ADDR_W  = DefAddrW
) (
  input  logic               clk,
  input  logic               CR,
  input  logic               load,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  output logic [ADDR_W-1:0]  addr
);

  localparam int unsigned AddrLsb = addr_lsb(PHASE_W, ADDR_W);

  logic [PHASE_W-1:0] phase;

  always_ff @(posedge clk) begin
    if (CR || load) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + freq_word;
    end
  end

  assign addr = phase[AddrLsb +: ADDR_W];

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: shadows a sweep configuration on start, steps the frequency
// word per dwell period, issues ROM reads from the phase accumulator and re-times ROM data
// into a sample stream.
//   clk, CR                  : clock, synchronous active-high reset
//   start, abort             : sweep request (IDLE only) / stop with drain, no done
//   cfg_fstart .. cfg_loop   : sweep configuration, sampled on an accepted start
//   rom_addr, rom_rd, rom_q  : waveform ROM read port (data ROM_LAT cycles after rom_rd)
//   sample_out, sample_valid : re-timed ROM data and its strobe
//   freq_word, step_idx      : current frequency word and 0-based step index
//   busy, done               : sweep in progress / one-cycle normal-completion pulse
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = DefPhaseW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               CR,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] cfg_fstart,
  input  logic [PHASE_W-1:0] cfg_fstep,
  input  logic [STEP_W-1:0]  cfg_nsteps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_rd,
  input  logic [DATA_W-1:0]  rom_q,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid,
  output logic [PHASE_W-1:0] freq_word,
  output logic [STEP_W-1:0]  step_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] DrainLast = 2'(ROM_LAT - 1);

  state_e             state;
  logic [PHASE_W-1:0] fstart_sh;
  logic [PHASE_W-1:0] fstep_sh;
  logic [STEP_W-1:0]  nsteps_m1_sh;
  logic [DWELL_W-1:0] dwell_m1_sh;
  logic               loop_sh;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [1:0]         drain_cnt;
  logic               aborted;
  logic [ROM_LAT-1:0] vpipe;

  logic               load;
  logic               dwell_end;
  logic               last_step;
  logic [STEP_W-1:0]  nsteps_m1;
  logic [DWELL_W-1:0] dwell_m1;

  // Zero counts behave as one.
  assign nsteps_m1 = (cfg_nsteps == '0) ? '0 : cfg_nsteps - STEP_W'(1);
  assign dwell_m1  = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);

  assign load      = (state == StIdle) && start && !abort;
  assign dwell_end = (dwell_cnt == dwell_m1_sh);
  assign last_step = (step_idx == nsteps_m1_sh);

  // Combinational so that abort (and reset) suppress the read in the same cycle.
  assign rom_rd = (state == StRun) && !abort && !CR;

  dds_phase_acc #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W)
  ) u_phase_acc (
    .clk       (clk),
    .CR        (CR),
    .load      (load),
    .en        (rom_rd),
    .freq_word (freq_word),
    .addr      (rom_addr)
  );

  always_ff @(posedge clk) begin
    if (CR) begin
      state        <= StIdle;
      fstart_sh    <= '0;
      fstep_sh     <= '0;
      nsteps_m1_sh <= '0;
      dwell_m1_sh  <= '0;
      loop_sh      <= 1'b0;
      freq_word    <= '0;
      step_idx     <= '0;
      dwell_cnt    <= '0;
      drain_cnt    <= '0;
      aborted      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vpipe        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      done <= 1'b0;

      // Valid pipeline mirrors the ROM latency; its tail marks rom_q as live.
      for (int i = ROM_LAT - 1; i > 0; i--) begin
        vpipe[i] <= vpipe[i-1];
      end
      vpipe[0]     <= rom_rd;
      sample_valid <= vpipe[ROM_LAT-1];
      if (vpipe[ROM_LAT-1]) begin
        sample_out <= rom_q;
      end

      unique case (state)
        StIdle: begin
          if (load) begin
            fstart_sh    <= cfg_fstart;
            fstep_sh     <= cfg_fstep;
            nsteps_m1_sh <= nsteps_m1;
            dwell_m1_sh  <= dwell_m1;
            loop_sh      <= cfg_loop;
            freq_word    <= cfg_fstart;
            step_idx     <= '0;
            dwell_cnt    <= '0;
            aborted      <= 1'b0;
            busy         <= 1'b1;
            state        <= StRun;
          end
        end

        StRun: begin
          if (abort) begin
            aborted   <= 1'b1;
            drain_cnt <= '0;
            state     <= StDrain;
          end else if (dwell_end) begin
            dwell_cnt <= '0;
            // The phase update in this cycle still uses the old freq_word.
            if (!last_step) begin
              freq_word <= freq_word + fstep_sh;
              step_idx  <= step_idx + STEP_W'(1);
            end else if (loop_sh) begin
              freq_word <= fstart_sh;
              step_idx  <= '0;
            end else begin
              drain_cnt <= '0;
              state     <= StDrain;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end

        StDrain: begin
          if (abort) begin
            aborted <= 1'b1;
          end
          if (drain_cnt == DrainLast) begin
            state <= StIdle;
            busy  <= 1'b0;
            done  <= !aborted && !abort;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer for the DDS datapath (phase accumulator feeding the waveform ROM). It latches a sweep configuration: start frequency word, step, step count, dwell and loop. It then steps the frequency word, advances the phase, and issues ROM addresses. Returned ROM data is re-timed into a sample stream with a valid strobe. The block sits between the control/register logic and the shared waveform ROM. It signals busy/done back to the control side.

Parameters:
PHASE_W, 16, phase accumulator and frequency word width
ADDR_W, 5, ROM address width; address = phase[PHASE_W-1 -: ADDR_W]
DATA_W, 8, ROM data / sample width
STEP_W, 8, width of step count and step index
DWELL_W, 16, width of dwell count (samples per frequency step)
ROM_LAT, 1, ROM read latency in clk cycles (1..3)

Ports:
clk  in  1  system clock, all logic on rising edge
CR  in  1  synchronous, active-high reset
start  in  1  single-cycle sweep request; honoured only in IDLE
abort  in  1  stop sweep, drain in-flight reads, no done pulse
cfg_fstart  in  PHASE_W  first frequency word
cfg_fstep  in  PHASE_W  frequency increment per step (mod 2^PHASE_W)
cfg_nsteps  in  STEP_W  number of frequency steps; 0 treated as 1
cfg_dwell  in  DWELL_W  samples per step; 0 treated as 1
cfg_loop  in  1  1 = restart from cfg_fstart after last step, until abort
rom_addr  out  ADDR_W  ROM read address, valid when rom_rd=1
rom_rd  out  1  read issued this cycle
rom_q  in  DATA_W  ROM data, ROM_LAT cycles after rom_rd
sample_out  out  DATA_W  registered sample; holds last value when not valid
sample_valid  out  1  sample_out updated this cycle
freq_word  out  PHASE_W  current frequency word
step_idx  out  STEP_W  current step index, 0-based
busy  out  1  high from the cycle after start until done or abort completes
done  out  1  one-cycle pulse at normal sweep completion

Behaviour:
- Reset: CR=1 at an edge clears state to IDLE and clears all outputs, phase, dwell counter and valid pipeline to 0. Reset mid-sweep discards in-flight reads: no sample_valid and no done afterwards.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On start=1 and abort=0, shadow all cfg_* inputs, set freq_word=cfg_fstart, phase=0, step_idx=0, dwell_cnt=0, then go to RUN.
  - busy rises in the next cycle.
  - start=1 together with abort=1 in IDLE: abort wins; stay in IDLE.
- RUN, every cycle:
  - rom_rd=1 and rom_addr=phase[MSBs] of the current phase.
  - Then phase += freq_word, wrapping mod 2^PHASE_W.
  - Dwell end (dwell_cnt == dwell-1) resets dwell_cnt to 0. Otherwise dwell_cnt increments.
  - At dwell end with step_idx < nsteps-1: freq_word += fstep (wraps), step_idx++. The new freq_word takes effect on the next phase update. Phase is not reset.
  - At dwell end with the last step and loop=1: freq_word=fstart, step_idx=0, phase continues.
  - At dwell end with the last step and loop=0: go to DRAIN after this read.
- abort in RUN: the read in that cycle is suppressed (rom_rd=0); go to DRAIN.
- DRAIN:
  - rom_rd=0.
  - Wait ROM_LAT cycles so every issued read produces sample_valid.
  - Then go to IDLE with busy=0.
  - On normal completion done=1 in that same cycle. On abort done stays 0.
- start while busy is ignored. cfg_* changes during a sweep have no effect because of the shadow registers.
- Sample path: a valid shift register of depth ROM_LAT tracks rom_rd. When it pops, sample_out<=rom_q and sample_valid=1. Samples therefore appear ROM_LAT+1 cycles after rom_rd.
- Non-loop sweep issues exactly nsteps*dwell reads.

Decomposition:
- Shared package dds_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - default widths PHASE_W, ADDR_W, DATA_W
  - constant for phase-to-address slicing
- One sub-module, dds_phase_acc: holds phase, accumulates freq_word on an enable, clears synchronously on load, and outputs the address slice.
- The FSM, dwell/step counters and valid pipeline stay in dds_sweep_ctrl.

Test Plan:
- The bench uses an identity ROM model with ROM_LAT=1 (q = zero-extended addr).
- Sweep: fstart=0x0800, fstep=0x0800, nsteps=3, dwell=4, loop=0. Expected sample sequence: 0,1,2,3,4,6,8,10,12,15,18,21. Exactly 12 sample_valid, done one pulse after the last read drains, busy low in the same cycle.
- Phase wrap: fstart=0x8000, nsteps=1, dwell=5. Expected samples 0,16,0,16,0, then done.
- Loop and abort: fstart=0x0800, fstep=0x0800, nsteps=2, dwell=2, loop=1. Expected samples 0,1,2,4,6,7,8,10,...
  - Assert abort after 6 reads: exactly 6 samples, no done, busy clears after drain.
- Degenerate config: nsteps=0, dwell=0, fstart=0x1000. Expected exactly one read, address 0, one sample 0, then done.
- Ignored and conflicting requests:
  - start pulsed mid-sweep with different cfg: sequence unchanged.
  - start+abort together in IDLE: busy stays 0.
- Reset mid-sweep: CR=1 after 3 reads. The next cycle shows all outputs 0 and IDLE, with no sample_valid or done. A fresh start runs normally.
